// File: rtl/ahb_master.sv
// rtl/ahb_master.sv - AHB-Lite initiator turning single commands into SINGLE/INCR transfers
// Address phase of beat n overlaps data phase of beat n-1; HREADY low freezes everything.
module ahb_master #(
   parameter int MAX_LEN = 16
) (
   input  logic        HCLK,
   input  logic        HRESET,
   input  logic        cmd_valid,
   output logic        cmd_ready,
   input  logic        cmd_write,
   input  logic [31:0] cmd_addr,
   input  logic [2:0]  cmd_size,
   input  logic [4:0]  cmd_len,
   input  logic [31:0] wr_data,
   output logic        wr_ready,
   output logic [31:0] rd_data,
   output logic        rd_valid,
   output logic        done,
   input  logic        HREADY,
   input  logic [31:0] HRDATA,
   output logic [31:0] HADDR,
   output logic [1:0]  HTRANS,
   output logic        HWRITE,
   output logic [2:0]  HSIZE,
   output logic [2:0]  HBURST,
   output logic [31:0] HWDATA
);
   localparam logic [1:0] S_IDLE  = 2'd0;
   localparam logic [1:0] S_ADDR  = 2'd1;
   localparam logic [1:0] S_BURST = 2'd2;
   localparam logic [1:0] S_LAST  = 2'd3;

   localparam logic [1:0] TR_IDLE   = 2'b00;
   localparam logic [1:0] TR_NONSEQ = 2'b10;
   localparam logic [1:0] TR_SEQ    = 2'b11;

   localparam logic [4:0] MAX_LEN_L = 5'(MAX_LEN);

   logic [1:0]  state_q, state_d;
   logic [31:0] haddr_q, haddr_d;
   logic [1:0]  htrans_q, htrans_d;
   logic        hwrite_q, hwrite_d;
   logic [2:0]  hsize_q, hsize_d;
   logic [2:0]  hburst_q, hburst_d;
   logic [31:0] hwdata_q, hwdata_d;
   logic [4:0]  rem_q, rem_d;
   logic [31:0] rd_data_q, rd_data_d;
   logic        rd_valid_q, rd_valid_d;
   logic        done_q, done_d;
   logic        cmd_ready_q, cmd_ready_d;

   logic        accept;
   logic        addr_go;
   logic        data_go;
   logic [2:0]  size_eff;
   logic [4:0]  len_eff;
   logic [31:0] incr;

   assign accept   = cmd_valid & cmd_ready_q;
   assign addr_go  = (htrans_q != TR_IDLE) & HREADY;
   assign data_go  = ((state_q == S_BURST) | (state_q == S_LAST)) & HREADY;
   assign size_eff = (cmd_size > 3'd2) ? 3'd2 : cmd_size;
   assign len_eff  = (cmd_len == 5'd0) ? 5'd1 :
                     ((cmd_len > MAX_LEN_L) ? MAX_LEN_L : cmd_len);
   assign incr     = 32'd1 << hsize_q;

   always_comb begin
      state_d     = state_q;
      haddr_d     = haddr_q;
      htrans_d    = htrans_q;
      hwrite_d    = hwrite_q;
      hsize_d     = hsize_q;
      hburst_d    = hburst_q;
      hwdata_d    = hwdata_q;
      rem_d       = rem_q;
      rd_data_d   = rd_data_q;
      rd_valid_d  = 1'b0;
      done_d      = 1'b0;

      case (state_q)
         S_IDLE: begin
            if (accept) begin
               state_d  = S_ADDR;
               htrans_d = TR_NONSEQ;
               haddr_d  = cmd_addr;
               hwrite_d = cmd_write;
               hsize_d  = size_eff;
               hburst_d = (len_eff == 5'd1) ? 3'b000 : 3'b001;
               rem_d    = len_eff - 5'd1;
            end
         end
         S_ADDR, S_BURST: begin
            // rem_q counts address phases still to issue after the current one
            if (HREADY) begin
               if (rem_q == 5'd0) begin
                  state_d  = S_LAST;
                  htrans_d = TR_IDLE;
               end else begin
                  state_d  = S_BURST;
                  htrans_d = TR_SEQ;
                  haddr_d  = haddr_q + incr;
                  rem_d    = rem_q - 5'd1;
               end
            end
         end
         S_LAST: begin
            if (HREADY) begin
               state_d = S_IDLE;
               done_d  = 1'b1;
            end
         end
         default: state_d = S_IDLE;
      endcase

      if (addr_go && hwrite_q) begin
         hwdata_d = wr_data;
      end
      if (data_go && !hwrite_q) begin
         rd_data_d  = HRDATA;
         rd_valid_d = 1'b1;
      end

      cmd_ready_d = (state_d == S_IDLE);
   end

   always_ff @(posedge HCLK) begin
      if (HRESET) begin
         state_q     <= S_IDLE;
         haddr_q     <= 32'd0;
         htrans_q    <= TR_IDLE;
         hwrite_q    <= 1'b0;
         hsize_q     <= 3'd0;
         hburst_q    <= 3'd0;
         hwdata_q    <= 32'd0;
         rem_q       <= 5'd0;
         rd_data_q   <= 32'd0;
         rd_valid_q  <= 1'b0;
         done_q      <= 1'b0;
         cmd_ready_q <= 1'b0;
      end else begin
         state_q     <= state_d;
         haddr_q     <= haddr_d;
         htrans_q    <= htrans_d;
         hwrite_q    <= hwrite_d;
         hsize_q     <= hsize_d;
         hburst_q    <= hburst_d;
         hwdata_q    <= hwdata_d;
         rem_q       <= rem_d;
         rd_data_q   <= rd_data_d;
         rd_valid_q  <= rd_valid_d;
         done_q      <= done_d;
         cmd_ready_q <= cmd_ready_d;
      end
   end

   assign cmd_ready = cmd_ready_q;
   assign wr_ready  = addr_go & hwrite_q;
   assign rd_data   = rd_data_q;
   assign rd_valid  = rd_valid_q;
   assign done      = done_q;
   assign HADDR     = haddr_q;
   assign HTRANS    = htrans_q;
   assign HWRITE    = hwrite_q;
   assign HSIZE     = hsize_q;
   assign HBURST    = hburst_q;
   assign HWDATA    = hwdata_q;

endmodule

// File: tb/tb_ahb_master.sv
// tb/tb_ahb_master.sv - self-checking bench for ahb_master with a beat-level bus model
module tb_ahb_master;
   logic        HCLK = 1'b0;
   logic        HRESET = 1'b1;
   logic        cmd_valid = 1'b0;
   logic        cmd_ready;
   logic        cmd_write = 1'b0;
   logic [31:0] cmd_addr = 32'd0;
   logic [2:0]  cmd_size = 3'd0;
   logic [4:0]  cmd_len = 5'd0;
   logic [31:0] wr_data = 32'd0;
   logic        wr_ready;
   logic [31:0] rd_data;
   logic        rd_valid;
   logic        done;
   logic        HREADY = 1'b1;
   logic [31:0] HRDATA = 32'd0;
   logic [31:0] HADDR;
   logic [1:0]  HTRANS;
   logic        HWRITE;
   logic [2:0]  HSIZE;
   logic [2:0]  HBURST;
   logic [31:0] HWDATA;

   int checks = 0;
   int failures = 0;
   logic [31:0] wdv [16];
   logic [31:0] rdv [16];

   always #5 HCLK = ~HCLK;

   ahb_master #(.MAX_LEN(16)) dut (
      .HCLK(HCLK), .HRESET(HRESET),
      .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_write(cmd_write),
      .cmd_addr(cmd_addr), .cmd_size(cmd_size), .cmd_len(cmd_len),
      .wr_data(wr_data), .wr_ready(wr_ready),
      .rd_data(rd_data), .rd_valid(rd_valid), .done(done),
      .HREADY(HREADY), .HRDATA(HRDATA),
      .HADDR(HADDR), .HTRANS(HTRANS), .HWRITE(HWRITE),
      .HSIZE(HSIZE), .HBURST(HBURST), .HWDATA(HWDATA)
   );

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   // Expected behaviour is tracked per beat: how many addresses the bus has
   // taken, which beat is in its data phase, and what must show up next cycle.
   task automatic do_cmd(input logic w, input logic [31:0] a, input logic [2:0] sz,
                         input logic [4:0] ln, input int wait_pct, input logic [31:0] stall_mask,
                         input int rst_at, output int cyc, output int acc_wait,
                         output int n_wr, output int n_rv);
      int len_e, n_acc, dp, rv_beat, waits;
      logic [2:0] sz_e;
      logic exp_rv, exp_done, hr, finished;
      len_e = (ln == 5'd0) ? 1 : ((ln > 5'd16) ? 16 : int'(ln));
      sz_e  = (sz > 3'd2) ? 3'd2 : sz;
      cmd_write = w; cmd_addr = a; cmd_size = sz; cmd_len = ln; cmd_valid = 1'b1;
      acc_wait = 0;
      while (cmd_ready !== 1'b1 && acc_wait < 50) begin
         @(negedge HCLK);
         acc_wait++;
      end
      chk("cmd_ready_at_accept", 32'(cmd_ready), 32'd1);
      @(posedge HCLK);
      n_acc = 0; dp = -1; rv_beat = 0; waits = 0;
      exp_rv = 1'b0; exp_done = 1'b0; finished = 1'b0;
      n_wr = 0; n_rv = 0; cyc = 0;
      for (int c = 1; c <= 300; c++) begin
         #1;
         hr = !((c < 32) ? stall_mask[c] : 1'b0) && (($urandom % 100) >= wait_pct);
         HREADY    = hr;
         HRDATA    = (dp >= 0) ? rdv[dp] : $urandom;
         wr_data   = (n_acc < len_e) ? wdv[n_acc] : $urandom;
         cmd_valid = exp_done ? 1'b0 : 1'($urandom_range(0, 1));
         cmd_write = 1'($urandom_range(0, 1));
         cmd_addr  = $urandom;
         cmd_size  = 3'($urandom_range(0, 7));
         cmd_len   = 5'($urandom_range(0, 31));
         if (c == rst_at) HRESET = 1'b1;
         @(negedge HCLK);
         if (n_acc < len_e) begin
            chk("htrans", 32'(HTRANS), (n_acc == 0) ? 32'd2 : 32'd3);
            chk("haddr", HADDR, a + (n_acc << sz_e));
         end else begin
            chk("htrans_idle", 32'(HTRANS), 32'd0);
         end
         chk("hwrite", 32'(HWRITE), 32'(w));
         chk("hsize", 32'(HSIZE), 32'(sz_e));
         chk("hburst", 32'(HBURST), (len_e == 1) ? 32'd0 : 32'd1);
         chk("wr_ready", 32'(wr_ready), 32'(w && (n_acc < len_e) && hr));
         if (w && dp >= 0) chk("hwdata", HWDATA, wdv[dp]);
         chk("rd_valid", 32'(rd_valid), 32'(exp_rv));
         if (exp_rv) chk("rd_data", rd_data, rdv[rv_beat]);
         chk("done", 32'(done), 32'(exp_done));
         chk("cmd_ready", 32'(cmd_ready), 32'(exp_done));
         n_wr += int'(wr_ready);
         n_rv += int'(rd_valid);
         if (exp_done) begin
            cyc = c;
            finished = 1'b1;
            chk("latency", 32'(c), 32'(len_e + 2 + waits));
            break;
         end
         @(posedge HCLK);
         if (c == rst_at) begin
            #1;
            HRESET = 1'b0; HREADY = 1'b1; cmd_valid = 1'b0;
            @(negedge HCLK);
            chk("rst_htrans", 32'(HTRANS), 32'd0);
            chk("rst_haddr", HADDR, 32'd0);
            chk("rst_hwdata", HWDATA, 32'd0);
            chk("rst_done", 32'(done), 32'd0);
            chk("rst_cmd_ready", 32'(cmd_ready), 32'd0);
            @(posedge HCLK);
            @(negedge HCLK);
            chk("post_rst_cmd_ready", 32'(cmd_ready), 32'd1);
            chk("post_rst_done", 32'(done), 32'd0);
            chk("post_rst_htrans", 32'(HTRANS), 32'd0);
            cyc = -1;
            return;
         end
         exp_rv   = (dp >= 0) && !w && hr;
         rv_beat  = (dp >= 0) ? dp : 0;
         exp_done = (dp == len_e - 1) && hr;
         if (!hr) begin
            waits++;
         end else begin
            dp = (n_acc < len_e) ? n_acc : -1;
            if (n_acc < len_e) n_acc++;
         end
      end
      chk("done_within_budget", 32'(finished), 32'd1);
   endtask

   initial begin
      int cyc, aw, nw, nr, len_r, bytes, off, gap;
      logic [2:0] sz_r, sz_e;
      logic [4:0] ln_r;

      HRESET = 1'b1;
      repeat (3) @(posedge HCLK);
      @(negedge HCLK);
      chk("reset_htrans", 32'(HTRANS), 32'd0);
      chk("reset_haddr", HADDR, 32'd0);
      chk("reset_hwrite", 32'(HWRITE), 32'd0);
      chk("reset_hsize", 32'(HSIZE), 32'd0);
      chk("reset_hburst", 32'(HBURST), 32'd0);
      chk("reset_hwdata", HWDATA, 32'd0);
      chk("reset_rd_data", rd_data, 32'd0);
      chk("reset_rd_valid", 32'(rd_valid), 32'd0);
      chk("reset_wr_ready", 32'(wr_ready), 32'd0);
      chk("reset_done", 32'(done), 32'd0);
      chk("reset_cmd_ready", 32'(cmd_ready), 32'd0);
      HRESET = 1'b0;
      @(negedge HCLK);
      chk("cmd_ready_after_reset", 32'(cmd_ready), 32'd1);

      wdv[0] = 32'hDEADBEEF;
      do_cmd(1'b1, 32'h100, 3'b010, 5'd1, 0, 32'h0, 0, cyc, aw, nw, nr);
      chk("single_write_cycles", 32'(cyc), 32'd3);
      chk("single_write_wr_ready", 32'(nw), 32'd1);
      repeat (2) @(negedge HCLK);

      rdv[0] = 32'h11; rdv[1] = 32'h22; rdv[2] = 32'h33; rdv[3] = 32'h44;
      do_cmd(1'b0, 32'h200, 3'b010, 5'd4, 0, 32'h8, 0, cyc, aw, nw, nr);
      chk("incr4_read_done_cycle", 32'(cyc), 32'd7);
      chk("incr4_read_rd_valid", 32'(nr), 32'd4);
      @(negedge HCLK);

      for (int i = 0; i < 16; i++) wdv[i] = $urandom;
      do_cmd(1'b1, 32'h3FA, 3'b001, 5'd3, 0, 32'h0, 0, cyc, aw, nw, nr);
      chk("half_burst_wr_ready", 32'(nw), 32'd3);
      chk("half_burst_cycles", 32'(cyc), 32'd5);
      @(negedge HCLK);

      do_cmd(1'b1, 32'h500, 3'b010, 5'd2, 0, 32'h6, 0, cyc, aw, nw, nr);
      chk("first_addr_wait_cycles", 32'(cyc), 32'd6);
      chk("first_addr_wait_wr_ready", 32'(nw), 32'd2);
      @(negedge HCLK);

      do_cmd(1'b1, 32'h600, 3'b010, 5'd8, 0, 32'h0, 3, cyc, aw, nw, nr);
      chk("reset_mid_burst_wr_ready", 32'(nw), 32'd3);

      for (int i = 0; i < 16; i++) rdv[i] = $urandom;
      do_cmd(1'b0, 32'h40, 3'b000, 5'd0, 0, 32'h0, 0, cyc, aw, nw, nr);
      chk("len0_cycles", 32'(cyc), 32'd3);
      chk("len0_rd_valid", 32'(nr), 32'd1);
      do_cmd(1'b1, 32'h80, 3'b001, 5'd2, 0, 32'h0, 0, cyc, aw, nw, nr);
      chk("b2b_accept_wait", 32'(aw), 32'd0);
      chk("b2b_wr_ready", 32'(nw), 32'd2);

      for (int t = 0; t < 40; t++) begin
         sz_r  = 3'($urandom_range(0, 7));
         ln_r  = 5'($urandom_range(0, 31));
         sz_e  = (sz_r > 3'd2) ? 3'd2 : sz_r;
         len_r = (ln_r == 5'd0) ? 1 : ((ln_r > 5'd16) ? 16 : int'(ln_r));
         bytes = 1 << sz_e;
         off   = $urandom_range(0, (1024 - len_r * bytes) / bytes) * bytes;
         for (int i = 0; i < 16; i++) begin
            wdv[i] = $urandom;
            rdv[i] = $urandom;
         end
         do_cmd(1'($urandom_range(0, 1)), ($urandom & 32'hFFFFFC00) | 32'(off), sz_r, ln_r,
                25, 32'h0, 0, cyc, aw, nw, nr);
         gap = $urandom_range(0, 2);
         repeat (gap) @(negedge HCLK);
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule

// File: doc/ahb_master.md
# ahb_master

AHB-Lite initiator that turns single-entry commands from local logic into AHB transfers. It drives `HADDR`, `HTRANS`, `HWRITE`, `HSIZE`, `HBURST` and `HWDATA`, and samples `HREADY` and `HRDATA` from the `ahb_slave` side of the bus. It supports SINGLE transfers and INCR bursts of 1–16 beats, with a pipelined address phase and data phase. There is no `HRESP`: every transfer completes OKAY.

## Interface
- `MAX_LEN`, default 16: maximum beats per command. `cmd_len` is clamped to this value.
- `HCLK` in 1: bus clock; all logic is on the rising edge.
- `HRESET` in 1: synchronous, active-high reset.
- `cmd_valid` in 1: command request.
- `cmd_ready` out 1: command accepted on the edge where both `cmd_valid` and `cmd_ready` are 1.
- `cmd_write` in 1: 1 = write, 0 = read.
- `cmd_addr` in 32: start address. Must be aligned to `cmd_size`.
- `cmd_size` in 3: HSIZE. Only 000, 001 and 010 are legal; other values are treated as 010.
- `cmd_len` in 5: beat count. 0 is treated as 1.
- `wr_data` in 32: write data for the current beat. Must be valid whenever `wr_ready` is 1.
- `wr_ready` out 1: `wr_data` is sampled on this edge.
- `rd_data` out 32: read data.
- `rd_valid` out 1: one-cycle pulse per read beat.
- `done` out 1: one-cycle pulse after the last data phase completes.
- `HREADY` in 1: slave ready.
- `HRDATA` in 32: slave read data.
- `HADDR` out 32, `HTRANS` out 2, `HWRITE` out 1, `HSIZE` out 3, `HBURST` out 3, `HWDATA` out 32: AHB outputs. All are registered.

## Operation
- **States:**
  - IDLE: `cmd_ready`=1, `HTRANS`=00.
  - ADDR: first beat, `HTRANS`=NONSEQ (10).
  - BURST: address phase of beat n overlaps data phase of beat n-1, `HTRANS`=SEQ (11).
  - LAST: data phase of the final beat, `HTRANS`=IDLE.
- **Transitions:**
  - IDLE→ADDR on command accept.
  - ADDR→BURST if len>1, else ADDR→LAST, on `HREADY`=1.
  - BURST→LAST when the last address is accepted (`HREADY`=1).
  - LAST→IDLE on `HREADY`=1.
- **Command latch:** on accept, latch write, addr, size and len; clamp len to 1..`MAX_LEN`.
- **HBURST:** 000 (SINGLE) if len=1, else 001 (INCR). It is constant for the whole command.
- **Address:** each accepted address phase increments `HADDR` by 1<<size. The 32-bit address wraps modulo 2^32. Commands must not cross a 1 KB boundary; the master does not split them.
- **Hold on wait states:** `HREADY`=0 holds every AHB output, including `HADDR`, `HTRANS` and `HWDATA`. Nothing advances.
- **Writes:**
  - `wr_ready`=1 in each cycle where a write address phase is accepted (`HTRANS`≠00 and `HREADY`=1).
  - `wr_data` is registered into `HWDATA` on that edge and held through the data phase.
- **Reads:**
  - In each read data-phase cycle with `HREADY`=1, `HRDATA` is registered to `rd_data`.
  - `rd_valid` pulses 1 on the following cycle.
  - `rd_data` holds its value until the next read beat.
- **Completion:** `done` pulses on the cycle after LAST completes. `cmd_ready` returns to 1 in that same cycle.
- **Reset:** synchronous and valid in any state, including mid-burst. The burst is abandoned, nothing resumes, and the next cycle shows IDLE values.

## Timing
- **Reset values:**
  - `HTRANS`=00, `HADDR`=0, `HWRITE`=0, `HSIZE`=000, `HBURST`=000, `HWDATA`=0.
  - `rd_data`=0, `rd_valid`=0, `wr_ready`=0, `done`=0.
  - `cmd_ready`=0 while `HRESET`=1, then 1 on the first cycle after reset.
- **Single write, zero waits:**
  - Accept at edge E0.
  - NONSEQ in cycle E0–E1; `wr_ready`=1 in that cycle.
  - Data phase E1–E2.
  - `done`=1 in E2–E3.
  - Total 3 cycles from accept to `done`.
- **N-beat burst, zero waits:** NONSEQ at cycle 1. `done` at cycle N+2. Address and data phases overlap on every cycle.
- **Read latency:** `rd_valid` for beat k follows `HRDATA` sampling by exactly 1 cycle.
- **Wait states:** each cycle with `HREADY`=0 adds exactly one cycle to the total.
- **Back-to-back commands:** the earliest next accept is in the `done` cycle. There is at least one IDLE bus cycle between commands.
- **Ignored input:** `cmd_valid` while `cmd_ready`=0 is ignored. There is no queueing.

## Test plan
- **Single write.** Addr 0x100, size 010, len 1, `wr_data` 0xDEADBEEF, `HREADY`=1.
  - Required: cycle 1 shows `HTRANS`=10, `HADDR`=0x100, `HBURST`=000, `HWRITE`=1.
  - Cycle 2: `HWDATA`=0xDEADBEEF, `HTRANS`=00.
  - Cycle 3: `done`=1.
- **4-beat INCR read, wait on beat 2.** Addr 0x200, size 010, `HRDATA`=0x11, 0x22, 0x33, 0x44, `HREADY`=0 for one cycle during the beat 2 data phase.
  - Required: `HADDR` sequence 0x200, 0x204, 0x208, 0x20C with `HTRANS` 10, 11, 11, 11.
  - Address 0x208 is held during the wait.
  - Four `rd_valid` pulses with 0x11..0x44.
  - `done` at cycle 7.
- **Halfword write burst.** Size 001, len 3, addr 0x3FA.
  - Required: `HADDR` 0x3FA, 0x3FC, 0x3FE.
  - `HSIZE`=001 throughout.
  - 3 `wr_ready` pulses.
- **Wait during first address phase.** `HREADY`=0 for 2 cycles during the first address phase.
  - Required: NONSEQ, `HADDR` and `wr_ready`=0 held.
  - `wr_ready` fires only when `HREADY` rises.
- **Reset mid-burst.** Assert `HRESET` during beat 3 of an 8-beat write.
  - Required: next cycle `HTRANS`=00, `done` never pulses.
  - `cmd_ready`=1 one cycle after reset deasserts.
- **Length clamp and back-to-back.** Command with len 0, then a second command presented continuously.
  - Required: exactly one beat, SINGLE.
  - Second command accepted in the `done` cycle; its NONSEQ appears the next cycle.
